// File: rtl/rgb_fader_pkg.sv
// Shared definitions for the RGB LED fader: state encoding, default sizing,
// and the packed-triple width helper used by upstream colour sequencers.
`define RGB_TRIPLE_W(bits) (3*(bits))

package rgb_fader_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_FADE = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_FADE = ST_FADE
    } state_t;

    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_STEP_DIV = 16384;

endpackage

// File: rtl/rgb_fader_pwm_channel.sv
// One colour channel: current/target duty, +/-1 ramp step, period-aligned
// shadow duty and the registered active-low PWM pin.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [PWM_BITS-1:0] tgt_in,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                pwm_wrap,
    output logic                eq,
    output logic                led
);

    logic [PWM_BITS-1:0] cur;
    logic [PWM_BITS-1:0] tgt;
    logic [PWM_BITS-1:0] shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur    <= '0;
            tgt    <= '0;
            shadow <= '0;
            led    <= 1'b1;
        end else begin
            if (load) begin
                tgt <= tgt_in;
            end
            if (step) begin
                if (cur < tgt) begin
                    cur <= cur + 1'b1;
                end else if (cur > tgt) begin
                    cur <= cur - 1'b1;
                end
            end
            // Shadow only moves at the period boundary so a period is never cut short.
            if (pwm_wrap) begin
                shadow <= cur;
            end
            led <= ~(pwm_cnt < shadow);
        end
    end

    assign eq = (cur == tgt);

endmodule

// File: rtl/rgb_fader.sv
// RGB LED fader top: handshake/fade state machine, step timer and the shared
// free-running PWM counter feeding three channel instances.
module rgb_fader
    import rgb_fader_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int STEP_DIV = DEF_STEP_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tgt_valid,
    output logic                tgt_ready,
    input  logic [PWM_BITS-1:0] tgt_r,
    input  logic [PWM_BITS-1:0] tgt_g,
    input  logic [PWM_BITS-1:0] tgt_b,
    output logic                busy,
    output logic                red_led,
    output logic                green_led,
    output logic                blue_led
);

    localparam int TW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [TW-1:0]       STEP_LAST = TW'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;

    state_t              state;
    state_t              state_nx;
    logic [TW-1:0]       step_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                accept;
    logic                step;
    logic                tick;
    logic                pwm_wrap;
    logic [2:0]          eq;

    assign tick     = (step_cnt == STEP_LAST);
    assign pwm_wrap = (pwm_cnt == PWM_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        case (state)
            S_IDLE: begin
                if (tgt_valid) begin
                    accept   = 1'b1;
                    state_nx = S_FADE;
                end
            end
            S_FADE: begin
                step = tick;
                if (&eq) begin
                    state_nx = S_IDLE;
                end
            end
        endcase
    end

    assign tgt_ready = (state == S_IDLE);
    assign busy      = (state == S_FADE);

    // Restarting on accept puts the first tick exactly STEP_DIV cycles out.
    always_ff @(posedge clk) begin
        if (rst || accept || tick) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (step),
        .tgt_in   (tgt_r),
        .pwm_cnt  (pwm_cnt),
        .pwm_wrap (pwm_wrap),
        .eq       (eq[0]),
        .led      (red_led)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (step),
        .tgt_in   (tgt_g),
        .pwm_cnt  (pwm_cnt),
        .pwm_wrap (pwm_wrap),
        .eq       (eq[1]),
        .led      (green_led)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (step),
        .tgt_in   (tgt_b),
        .pwm_cnt  (pwm_cnt),
        .pwm_wrap (pwm_wrap),
        .eq       (eq[2]),
        .led      (blue_led)
    );

endmodule
